// File: rtl/hamming_enc_sequencer.sv
// Hamming SECDED encode sequencer: reads 11-bit messages as byte pairs,
// writes 16-bit encoded words back to the destination region.
module hamming_enc_sequencer #(
  parameter int unsigned NUM_MSG  = 15,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 30,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic          busy,
  output logic          done,
  output logic [3:0]    msg_idx
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_MSG - 1);

  state_t        state;
  state_t        nxt;
  logic [11:1]   d;
  logic [AW-1:0] off;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic          p0;
  logic          p1;
  logic          p2;
  logic          p4;
  logic          p8;

  assign off      = AW'({msg_idx, 1'b0});
  assign src_addr = AW'(SRC_BASE) + off;
  assign dst_addr = AW'(DST_BASE) + off;

  assign p8 = ^d[11:5];
  assign p4 = (^d[11:8]) ^ (^d[4:2]);
  assign p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
  assign p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
  assign p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      msg_idx <= '0;
      d       <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE, DONE: if (start) msg_idx <= '0;
        RD_LO:      d[8:1] <= mem_rd_data;
        RD_HI:      d[11:9] <= mem_rd_data[2:0];
        WR_HI:      if (msg_idx != LAST) msg_idx <= msg_idx + 4'd1;
        default:    ;
      endcase
    end
  end

  // Outputs depend only on registered state, index and latched data.
  always_comb begin
    nxt         = state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    unique case (state)
      IDLE: begin
        if (start) nxt = RD_LO;
      end
      RD_LO: begin
        busy     = 1'b1;
        mem_addr = src_addr;
        nxt      = RD_HI;
      end
      RD_HI: begin
        busy     = 1'b1;
        mem_addr = src_addr + AW'(1);
        nxt      = WR_LO;
      end
      WR_LO: begin
        busy        = 1'b1;
        mem_addr    = dst_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = {d[4:2], p4, d[1], p2, p1, p0};
        nxt         = WR_HI;
      end
      WR_HI: begin
        busy        = 1'b1;
        mem_addr    = dst_addr + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = {d[11:5], p8};
        nxt         = (msg_idx == LAST) ? DONE : RD_LO;
      end
      DONE: begin
        done = 1'b1;
        if (start) nxt = RD_LO;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule
